hazard_forward_unit: RTL

Sequential hazard controller for the 5-stage RISC-V pipeline. It tracks destination-register state for the EX, MEM and WB slots in its own scoreboard. It produces the registered 2-bit select codes that drive the EX-stage operand forwarding muxes, detects load-use hazards and issues a one-cycle stall, and applies branch flushes. It sits between the ID stage and the EX-stage operand muxes.

---
 rtl/hazard_forward_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard controller for a 5-stage RISC-V pipeline. It keeps a private
// scoreboard of the EX/MEM/WB destination registers. From it the unit
// produces the registered EX operand-forwarding selects, a one-cycle
// load-use stall, the branch flush, and saturating stall/flush event counters.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             ifid_flush,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             id_enters;

    // A slot produces register r only if it is a real, writing instruction
    // and r is not the hard-wired zero register.
    function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != 5'd0);
    endfunction

    // Select for one source operand. EX/MEM beats MEM/WB. A hit in WB
    // needs no path because the register file is write-first.
    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input slot_t wb_s, input logic [4:0] r);
        logic [1:0] sel;
        sel = SEL_RF;
        if (slot_writes(ex_s, r)) begin
            sel = SEL_EXMEM;
        end else if (slot_writes(mem_s, r)) begin
            sel = SEL_MEMWB;
        end else if (slot_writes(wb_s, r)) begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection, slot advance, forward selects and counter updates.
    always_comb begin
        stall       = 1'b0;
        ifid_flush  = ex_flush;
        id_enters   = 1'b0;
        ex_d        = '0;
        mem_d       = ex_q;
        wb_d        = mem_q;
        fwd_a_d     = SEL_RF;
        fwd_b_d     = SEL_RF;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A load still in EX cannot feed ID's sources yet. Any name match
        // stalls, because the sources are not decoded for actual use.
        stall = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                (ex_q.rd != 5'd0) &&
                ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !ex_flush;

        id_enters = id_valid && !stall && !ex_flush;

        if (id_enters) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            // Compare against the pre-edge EX and MEM slots. After the edge
            // they sit in EX/MEM and MEM/WB.
            fwd_a_d = fwd_sel(ex_q, mem_q, wb_q, id_rs1);
            fwd_b_d = fwd_sel(ex_q, mem_q, wb_q, id_rs2);
        end

        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers. Reset empties the scoreboard completely.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign forward_a = fwd_a_q;
    assign forward_b = fwd_b_q;
    assign ex_bubble = !ex_q.valid;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
